// File: rtl/branch_ctrl_pkg.sv
// Shared encodings for the branch controller: condition codes, flag bit positions, FSM states.
package branch_pkg;

  typedef enum logic [2:0] {
    CC_NEQ    = 3'b000,
    CC_EQ     = 3'b001,
    CC_GT     = 3'b010,
    CC_LT     = 3'b011,
    CC_GTE    = 3'b100,
    CC_LTE    = 3'b101,
    CC_OVFL   = 3'b110,
    CC_UNCOND = 3'b111
  } cc_e;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WAIT_FLAGS = 2'b01,
    REDIRECT   = 2'b10
  } state_e;

endpackage

// File: rtl/branch_ctrl_if.sv
// Bundle between the pipeline (master) and the branch controller (slave).
interface branch_ctrl_if #(
  parameter int ADDR_W = 16
) ();

  logic              stall_in;
  logic              br_valid;
  logic [2:0]        br_cond;
  logic [ADDR_W-1:0] br_target;
  logic              ex_sets_flags;
  logic [2:0]        flag_wr_en;
  logic [2:0]        alu_flags;
  logic [2:0]        flag_reg;
  logic              stall_out;
  logic              pc_sel;
  logic              flush;
  logic [ADDR_W-1:0] pc_target;

  modport master (
    output stall_in, br_valid, br_cond, br_target, ex_sets_flags, flag_wr_en, alu_flags,
    input  flag_reg, stall_out, pc_sel, flush, pc_target
  );

  modport slave (
    input  stall_in, br_valid, br_cond, br_target, ex_sets_flags, flag_wr_en, alu_flags,
    output flag_reg, stall_out, pc_sel, flush, pc_target
  );

endinterface

// File: rtl/branch_ctrl_cond_eval.sv
// Combinational branch condition evaluator: ccc code against an {N,Z,V} flag set.
module cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       taken_o
);

  logic n, z, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign v = flags_i[FLAG_V];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      CC_NEQ:    taken_o = ~z;
      CC_EQ:     taken_o = z;
      CC_GT:     taken_o = ~z & ~n;
      CC_LT:     taken_o = n;
      CC_GTE:    taken_o = z | ~n;
      CC_LTE:    taken_o = n | z;
      CC_OVFL:   taken_o = v;
      CC_UNCOND: taken_o = 1'b1;
      default:   taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution sequencer: owns the {N,Z,V} flags and issues a registered one-cycle redirect.
// Define BRANCH_FLAG_BYPASS_EN to forward EX flag writes into evaluation instead of stalling.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  branch_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  logic [2:0]        flags_q, flags_d;
  logic [2:0]        heldCond_q, heldCond_d;
  logic [ADDR_W-1:0] heldTarget_q, heldTarget_d;
  logic [ADDR_W-1:0] pcTarget_q, pcTarget_d;
  logic              hazard;
  logic              hazardStall;
  logic [2:0]        idleFlags;
  logic [2:0]        evalCond;
  logic [2:0]        evalFlags;
  logic              taken;

  assign flags_d = (bus.flag_wr_en & bus.alu_flags) | (~bus.flag_wr_en & flags_q);

`ifdef BRANCH_FLAG_BYPASS_EN
  assign hazard    = 1'b0;
  assign idleFlags = flags_d;
`else
  assign hazard    = bus.ex_sets_flags;
  assign idleFlags = flags_q;
`endif

  // A branch parked in WAIT_FLAGS is re-evaluated from its held ccc against the freshly written flags.
  assign evalCond  = (state_q == WAIT_FLAGS) ? heldCond_q : bus.br_cond;
  assign evalFlags = (state_q == WAIT_FLAGS) ? flags_q : idleFlags;

  cond_eval u_cond_eval (
    .cond_i  (evalCond),
    .flags_i (evalFlags),
    .taken_o (taken)
  );

  always_comb begin
    state_d      = state_q;
    heldCond_d   = heldCond_q;
    heldTarget_d = heldTarget_q;
    pcTarget_d   = pcTarget_q;
    hazardStall  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.br_valid) begin
          if (hazard) begin
            hazardStall  = 1'b1;
            heldCond_d   = bus.br_cond;
            heldTarget_d = bus.br_target;
            state_d      = WAIT_FLAGS;
          end else if (taken) begin
            pcTarget_d = bus.br_target;
            state_d    = REDIRECT;
          end
        end
      end
      WAIT_FLAGS: begin
        if (taken) begin
          pcTarget_d = heldTarget_q;
          state_d    = REDIRECT;
        end else begin
          state_d = IDLE;
        end
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      flags_q      <= 3'b000;
      heldCond_q   <= 3'b000;
      heldTarget_q <= '0;
      pcTarget_q   <= '0;
    end else if (!bus.stall_in) begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      heldCond_q   <= heldCond_d;
      heldTarget_q <= heldTarget_d;
      pcTarget_q   <= pcTarget_d;
    end
  end

  assign bus.flag_reg  = flags_q;
  assign bus.stall_out = hazardStall;
  assign bus.pc_sel    = (state_q == REDIRECT);
  assign bus.flush     = (state_q == REDIRECT);
  assign bus.pc_target = pcTarget_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized scoreboard bench for branch_ctrl; expected redirects are queued by stimulus and popped by a monitor.
module tb_branch_ctrl;
  import branch_pkg::*;

  typedef struct {
    int          cycle;
    logic [15:0] target;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cycleNum = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  logic [2:0] modelFlags = 3'b000;
  bit   prevPc = 1'b0;
  bit   prevStall = 1'b0;

  branch_ctrl_if #(.ADDR_W(16)) bus ();

  branch_ctrl #(.ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycleNum);
    end
  endtask

  // Truth table of the ccc field, straight from the condition rules.
  function automatic bit refTaken(input logic [2:0] c, input logic [2:0] f);
    bit n, z, v;
    n = f[2];
    z = f[1];
    v = f[0];
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || !n;
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] applyWrite(input logic [2:0] f, input logic [2:0] en, input logic [2:0] val);
    return (f & ~en) | (val & en);
  endfunction

  task automatic applyStimulus(input bit valid, input logic [2:0] cond, input logic [15:0] tgt,
                               input bit exSets, input logic [2:0] wrEn, input logic [2:0] alu,
                               input bit stall);
    bus.br_valid      = valid;
    bus.br_cond       = cond;
    bus.br_target     = tgt;
    bus.ex_sets_flags = exSets;
    bus.flag_wr_en    = wrEn;
    bus.alu_flags     = alu;
    bus.stall_in      = stall;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doIdle(input bit stall, input logic [2:0] wrEn, input logic [2:0] alu);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, wrEn, alu, stall);
    checkOutput("stall_out_idle", bus.stall_out, 1'b0);
    if (!stall) modelFlags = applyWrite(modelFlags, wrEn, alu);
    nextCycle();
    checkOutput("flag_reg", bus.flag_reg, modelFlags);
  endtask

  task automatic doBranch(input logic [2:0] cond, input logic [15:0] tgt, input bit hazard,
                          input logic [2:0] wrEn, input logic [2:0] alu);
    logic [2:0] pre, post, rdEn, rdAlu;
    bit taken, stallExp, waitCycle;
    int lat;
    pre  = modelFlags;
    post = applyWrite(pre, wrEn, alu);
`ifdef BRANCH_FLAG_BYPASS_EN
    taken     = refTaken(cond, post);
    stallExp  = 1'b0;
    waitCycle = 1'b0;
    lat       = 1;
`else
    taken     = hazard ? refTaken(cond, post) : refTaken(cond, pre);
    stallExp  = hazard;
    waitCycle = hazard;
    lat       = hazard ? 2 : 1;
`endif
    applyStimulus(1'b1, cond, tgt, hazard, wrEn, alu, 1'b0);
    checkOutput("stall_out_branch", bus.stall_out, stallExp);
    if (taken) expQ.push_back('{cycleNum + lat, tgt});
    modelFlags = post;
    nextCycle();
    checkOutput("flag_reg", bus.flag_reg, modelFlags);
    if (waitCycle) begin
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'b000, 3'b000, 1'b0);
      checkOutput("stall_out_wait", bus.stall_out, 1'b0);
      nextCycle();
    end
    if (taken) begin
      // The ID instruction during the redirect is being flushed, so drive junk at it.
      rdEn  = 3'($urandom);
      rdAlu = 3'($urandom);
      applyStimulus(1'b1, 3'($urandom), 16'($urandom), 1'($urandom), rdEn, rdAlu, 1'b0);
      checkOutput("stall_out_redirect", bus.stall_out, 1'b0);
      modelFlags = applyWrite(modelFlags, rdEn, rdAlu);
      nextCycle();
      checkOutput("flag_reg", bus.flag_reg, modelFlags);
    end
  endtask

  // Monitor: every fresh redirect must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (expQ.size() > 0 && expQ[0].cycle < cycleNum) begin
        e = expQ.pop_front();
        checkOutput("redirect_missing", 32'(e.cycle), 32'(cycleNum));
      end
      if (bus.pc_sel === 1'b1 && !(prevPc && prevStall)) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_redirect", bus.pc_sel, 1'b0);
        end else begin
          e = expQ.pop_front();
          checkOutput("redirect_cycle", 32'(cycleNum), 32'(e.cycle));
          checkOutput("pc_target", bus.pc_target, e.target);
          checkOutput("flush", bus.flush, 1'b1);
        end
      end else if (bus.pc_sel === 1'b0) begin
        checkOutput("flush_quiet", bus.flush, 1'b0);
      end
    end
    prevPc    = (bus.pc_sel === 1'b1);
    prevStall = (bus.stall_in === 1'b1);
  end

  initial begin
    bit tk;
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'b000, 3'b000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_flag_reg", bus.flag_reg, 3'b000);
    checkOutput("reset_pc_sel", bus.pc_sel, 1'b0);
    checkOutput("reset_flush", bus.flush, 1'b0);
    checkOutput("reset_pc_target", bus.pc_target, 16'h0);
    checkOutput("reset_stall_out", bus.stall_out, 1'b0);
    rst = 1'b0;
    modelFlags = 3'b000;
    nextCycle();

    $display("[TB] flag register writes");
    doIdle(1'b0, 3'b111, 3'b010);
    checkOutput("flag_write_all", bus.flag_reg, 3'b010);
    doIdle(1'b0, 3'b100, 3'b101);
    checkOutput("flag_write_n_only", bus.flag_reg, 3'b110);

    $display("[TB] simple taken / not-taken");
    doIdle(1'b0, 3'b111, 3'b010);
    doBranch(CC_EQ, 16'h0040, 1'b0, 3'b000, 3'b000);
    doBranch(CC_NEQ, 16'h0050, 1'b0, 3'b000, 3'b000);
    doIdle(1'b0, 3'b000, 3'b000);

    $display("[TB] flag hazard");
    doIdle(1'b0, 3'b111, 3'b000);
    doBranch(CC_LT, 16'h0080, 1'b1, 3'b111, 3'b100);
    doIdle(1'b0, 3'b000, 3'b000);

    $display("[TB] condition sweep");
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        doIdle(1'b0, 3'b111, 3'(f));
        doBranch(3'(c), 16'($urandom), 1'b0, 3'b000, 3'b000);
      end
    end

    $display("[TB] stall held in redirect");
    doIdle(1'b0, 3'b111, 3'b010);
    applyStimulus(1'b1, CC_EQ, 16'h1234, 1'b0, 3'b000, 3'b000, 1'b0);
    expQ.push_back('{cycleNum + 1, 16'h1234});
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'b111, 3'b101, 1'b1);
      checkOutput("pc_sel_stalled", bus.pc_sel, 1'b1);
      checkOutput("flush_stalled", bus.flush, 1'b1);
      nextCycle();
      checkOutput("flag_reg_stalled", bus.flag_reg, modelFlags);
    end
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'b000, 3'b000, 1'b0);
    checkOutput("pc_sel_release", bus.pc_sel, 1'b1);
    nextCycle();
    checkOutput("pc_sel_dropped", bus.pc_sel, 1'b0);
    checkOutput("flush_dropped", bus.flush, 1'b0);

    $display("[TB] reset during hazard wait");
    doIdle(1'b0, 3'b111, 3'b000);
    applyStimulus(1'b1, CC_LT, 16'h0BAD, 1'b1, 3'b111, 3'b100, 1'b0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'b000, 3'b000, 1'b0);
    checkOutput("rst_pc_sel", bus.pc_sel, 1'b0);
    checkOutput("rst_flush", bus.flush, 1'b0);
    checkOutput("rst_stall_out", bus.stall_out, 1'b0);
    checkOutput("rst_flag_reg", bus.flag_reg, 3'b000);
    checkOutput("rst_pc_target", bus.pc_target, 16'h0);
    nextCycle();
    rst = 1'b0;
    modelFlags = 3'b000;
    for (int i = 0; i < 4; i++) doIdle(1'b0, 3'b000, 3'b000);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 2))
        0: doIdle(($urandom_range(0, 3) == 0), 3'($urandom), 3'($urandom));
        1: doBranch(3'($urandom), 16'($urandom), 1'b0, 3'($urandom), 3'($urandom));
        default: doBranch(3'($urandom), 16'($urandom), 1'b1, 3'($urandom), 3'($urandom));
      endcase
    end

    for (int i = 0; i < 4; i++) doIdle(1'b0, 3'b000, 3'b000);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
